// File: rtl/risc_control_unit.sv
// Control and sequencing stage for the single-cycle RISC datapath.
// Decodes the current instruction, owns the NZCV flag register and runs the LOAD/START/RUN/HALT FSM.
module risc_control_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             load_req,
   input  logic [15:0]      instr,
   input  logic             Pre_C,
   input  logic             Pre_V,
   input  logic             Pre_Z,
   input  logic             Pre_N,
   output logic             test_normal,
   output logic             flag_HLT,
   output logic             pc_clr,
   output logic             Src_Read_B,
   output logic             Src_ALU_B,
   output logic             ADC,
   output logic             SUB,
   output logic             SBB,
   output logic             JMP,
   output logic             BRANCH,
   output logic             flag_label_PC,
   output logic             flag_Rm_PC,
   output logic             flag_Rd_PC,
   output logic             flag_mem_RF,
   output logic             flag_ALU_RF,
   output logic             flag_Rm_RF,
   output logic             flag_PC_RF,
   output logic             LHI,
   output logic             LLI,
   output logic             RF_write_en,
   output logic             data_write_en,
   output logic             flag_OutR,
   output logic             flag_C,
   output logic             flag_V,
   output logic             flag_Z,
   output logic             flag_N,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   typedef enum logic [4:0] {
      OP_ALU   = 5'b00000,
      OP_LHI   = 5'b00001,
      OP_LLI   = 5'b00010,
      OP_LDR   = 5'b00011,
      OP_MOV   = 5'b00100,
      OP_STR   = 5'b00101,
      OP_CMP   = 5'b00110,
      OP_ADDI  = 5'b00111,
      OP_SUBI  = 5'b01000,
      OP_JMP   = 5'b10000,
      OP_JAL   = 5'b10001,
      OP_JALR  = 5'b10010,
      OP_JR    = 5'b10011,
      OP_BCC0  = 5'b11000,
      OP_BCC1  = 5'b11001,
      OP_OUTR  = 5'b11100,
      OP_HLT   = 5'b11111
   } opcode_e;

   state_e           state_q, state_d;
   logic [3:0]       flags_q, flags_d;   // {C, V, Z, N}
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       opcode;

   assign opcode = instr[15:11];

   // Evaluates a 4-bit branch condition against the registered flags.
   function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
      logic c, v, z, n;
      {c, v, z, n} = f;
      case (cond)
         4'h0:    return z;
         4'h1:    return !z;
         4'h2:    return c;
         4'h3:    return !c;
         4'h4:    return n;
         4'h5:    return !n;
         4'h6:    return v;
         4'h7:    return !v;
         4'h8:    return c && !z;
         4'h9:    return !c || z;
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return !z && (n == v);
         4'hD:    return z || (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
      state_d       = state_q;
      flags_d       = flags_q;
      cnt_d         = cnt_q;
      test_normal   = 1'b0;
      flag_HLT      = 1'b0;
      pc_clr        = 1'b0;
      Src_Read_B    = 1'b0;
      Src_ALU_B     = 1'b0;
      ADC           = 1'b0;
      SUB           = 1'b0;
      SBB           = 1'b0;
      JMP           = 1'b0;
      BRANCH        = 1'b0;
      flag_label_PC = 1'b0;
      flag_Rm_PC    = 1'b0;
      flag_Rd_PC    = 1'b0;
      flag_mem_RF   = 1'b0;
      flag_ALU_RF   = 1'b0;
      flag_Rm_RF    = 1'b0;
      flag_PC_RF    = 1'b0;
      LHI           = 1'b0;
      LLI           = 1'b0;
      RF_write_en   = 1'b0;
      data_write_en = 1'b0;
      flag_OutR     = 1'b0;

      case (state_q)
         ST_LOAD: begin
            test_normal = 1'b1;
            if (start) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            pc_clr  = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            flag_HLT = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            case (opcode)
               OP_ALU: begin
                  ADC         = (instr[1:0] == 2'b01);
                  SUB         = (instr[1:0] == 2'b10);
                  SBB         = (instr[1:0] == 2'b11);
                  flag_ALU_RF = 1'b1;
                  RF_write_en = 1'b1;
                  flags_d     = {Pre_C, Pre_V, Pre_Z, Pre_N};
               end
               OP_LHI: begin
                  LHI         = 1'b1;
                  Src_Read_B  = 1'b1;
                  RF_write_en = 1'b1;
               end
               OP_LLI: begin
                  LLI         = 1'b1;
                  RF_write_en = 1'b1;
               end
               OP_LDR: begin
                  Src_ALU_B   = 1'b1;
                  flag_mem_RF = 1'b1;
                  RF_write_en = 1'b1;
               end
               OP_MOV: begin
                  flag_Rm_RF  = 1'b1;
                  RF_write_en = 1'b1;
               end
               OP_STR: begin
                  Src_ALU_B     = 1'b1;
                  Src_Read_B    = 1'b1;
                  data_write_en = 1'b1;
               end
               OP_CMP: begin
                  SUB     = 1'b1;
                  flags_d = {Pre_C, Pre_V, Pre_Z, Pre_N};
               end
               OP_ADDI: begin
                  Src_ALU_B   = 1'b1;
                  flag_ALU_RF = 1'b1;
                  RF_write_en = 1'b1;
                  flags_d     = {Pre_C, Pre_V, Pre_Z, Pre_N};
               end
               OP_SUBI: begin
                  SUB         = 1'b1;
                  Src_ALU_B   = 1'b1;
                  flag_ALU_RF = 1'b1;
                  RF_write_en = 1'b1;
                  flags_d     = {Pre_C, Pre_V, Pre_Z, Pre_N};
               end
               OP_JMP: begin
                  JMP           = 1'b1;
                  flag_label_PC = 1'b1;
               end
               OP_JAL: begin
                  BRANCH      = 1'b1;
                  flag_PC_RF  = 1'b1;
                  RF_write_en = 1'b1;
               end
               OP_JALR: begin
                  JMP         = 1'b1;
                  flag_Rm_PC  = 1'b1;
                  flag_PC_RF  = 1'b1;
                  RF_write_en = 1'b1;
               end
               OP_JR: begin
                  JMP        = 1'b1;
                  flag_Rd_PC = 1'b1;
               end
               OP_BCC0, OP_BCC1: BRANCH = cond_true(instr[11:8], flags_q);
               OP_OUTR: flag_OutR = 1'b1;
               OP_HLT: begin
                  flag_HLT = 1'b0;
                  state_d  = ST_HALT;
               end
               default: ;
            endcase
         end
         ST_HALT: begin
            test_normal = 1'b1;
            if (start) begin
               state_d = ST_START;
               cnt_d   = '0;
            end else if (load_req) begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_LOAD;
         flags_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   assign {flag_C, flag_V, flag_Z, flag_N} = flags_q;
   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
- Control/sequencing stage directly upstream of Datapath_Module in the single-cycle RISC.
- Consumes the fetched instruction (mem_instr_out) and the datapath's pre-computed ALU flags (Pre_C/V/Z/N).
- Produces every datapath control strobe each cycle, owns the architectural NZCV flag register, and runs the LOAD/START/RUN/HALT sequencing FSM that today is hand-driven by benches.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous active-high
- start  in  1  leave LOAD/HALT and begin execution from PC 0
- load_req  in  1  return from HALT to LOAD; ignored in RUN
- instr  in  16  current instruction (datapath mem_instr_out)
- Pre_C, Pre_V, Pre_Z, Pre_N  in  1 each  pre-computed ALU flags of the current instruction
- test_normal  out  1  1 = external memory access mode
- flag_HLT  out  1  1 = PC advances
- pc_clr  out  1  datapath PC/clear strobe
- Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, BRANCH  out  1 each  datapath controls
- flag_label_PC, flag_Rm_PC, flag_Rd_PC  out  1 each  PC source selects
- flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF  out  1 each  RF write-data selects
- LHI, LLI, RF_write_en, data_write_en, flag_OutR  out  1 each  datapath controls
- flag_C, flag_V, flag_Z, flag_N  out  1 each  registered flags; flag_C is the carry-in for ADC/SBB
- state  out  2  FSM state: LOAD=0, START=1, RUN=2, HALT=3
- instr_count  out  CNT_W  instructions retired since last START

Behaviour:
- Reset (clr=1, asynchronous):
  - state=LOAD; flags=0; instr_count=0.
  - Outputs: test_normal=1, every other output 0.
- FSM transitions:
  - LOAD: start -> START.
  - START: lasts exactly 1 cycle, then RUN. pc_clr=1, test_normal=0, flag_HLT=0; instr_count cleared.
  - RUN: opcode HLT -> HALT at the next edge.
  - HALT: start -> START (start has priority over load_req); load_req -> LOAD.
- Per-state outputs:
  - LOAD and HALT: test_normal=1, flag_HLT=0, all strobes 0.
  - RUN: test_normal=0, flag_HLT=1 except on a HLT instruction (flag_HLT=0).
- Decode in RUN only:
  - Combinational from instr, same cycle, zero latency. All strobes not listed below are 0. Opcode = instr[15:11].
  - 00000 ALU reg, func=instr[1:0]:
    - 00 ADD; 01 ADC (ADC=1); 10 SUB (SUB=1); 11 SBB (SBB=1).
    - All four: flag_ALU_RF=1, RF_write_en=1.
  - 00001 LHI: LHI=1, Src_Read_B=1, RF_write_en=1.
  - 00010 LLI: LLI=1, RF_write_en=1.
  - 00011 LDR: Src_ALU_B=1, flag_mem_RF=1, RF_write_en=1.
  - 00100 MOV: flag_Rm_RF=1, RF_write_en=1.
  - 00101 STR: Src_ALU_B=1, Src_Read_B=1, data_write_en=1.
  - 00110 CMP: SUB=1, RF_write_en=0.
  - 00111 ADDI: Src_ALU_B=1, flag_ALU_RF=1, RF_write_en=1.
  - 01000 SUBI: SUB=1, Src_ALU_B=1, flag_ALU_RF=1, RF_write_en=1.
  - 10000 JMP: JMP=1, flag_label_PC=1.
  - 10001 JAL label: BRANCH=1, flag_PC_RF=1, RF_write_en=1.
  - 10010 JAL Rm: JMP=1, flag_Rm_PC=1, flag_PC_RF=1, RF_write_en=1.
  - 10011 JR Rd: JMP=1, flag_Rd_PC=1.
  - 11000-11001 Bcond: cond=instr[11:8]; BRANCH=1 only if cond true, else 0.
  - 11100 OutR: flag_OutR=1.
  - 11111 HLT.
  - All other opcodes: NOP (strobes 0, PC advances).
- Branch conditions use the registered flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F NV 0.
- Flag register:
  - At the rising edge in RUN, for ADD/ADC/SUB/SBB/ADDI/SUBI/CMP: {C,V,Z,N} <= {Pre_C,Pre_V,Pre_Z,Pre_N}.
  - Otherwise flags hold, including across HALT and LOAD.
  - Flags are cleared only by clr. START does not clear flags.
- instr_count: +1 per RUN cycle, including the HLT cycle. Saturates at all-ones and does not wrap.
- Reset mid-RUN: outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset/sequencing: clr=1 -> state=0, test_normal=1, all strobes 0; release, pulse start -> exactly 1 cycle with pc_clr=1, then state=2, flag_HLT=1.
- Decode sweep: in RUN, apply instr 16'b00011_001_000_00000 -> Src_ALU_B=1, flag_mem_RF=1, RF_write_en=1, rest 0; repeat for every listed opcode against the table above.
- Flags/branch: SUB with Pre_Z=1, Pre_C=1 -> next cycle flag_Z=1, flag_C=1; instr 1100_0000_xxxxxxxx -> BRANCH=1; instr 1100_0001_... -> BRANCH=0; instr 1100_1110_... -> BRANCH=1 with any flags.
- Flag hold: an LDR after the SUB, with Pre_Z=0 -> flag_Z stays 1; ADC asserted -> flag_C output is 1.
- HLT: instr 16'hF800 -> flag_HLT=0 that cycle, next state=3, test_normal=1; start -> START -> RUN with instr_count=0; load_req in HALT -> LOAD.
- Boundaries: drive clr mid-RUN between edges -> outputs reset asynchronously, flags 0; with CNT_W=4, run 20 cycles -> instr_count=4'hF.
